mac_feeder: RTL and testbench

- Operand sequencer and the upstream end of the 4-lane MAC datapath (drives mac_wrapper inputs a0..b3 and c; consumes its out).
- Accepts a stream of 4-lane operand chunks over a valid/ready handshake and issues one chunk per MAC pass.
- Feeds each returned partial sum back on c to accumulate a dot product of len chunks.
- Presents the final psum on a result valid/ready handshake.

---
 rtl/mac_feeder_pkg.sv | 14 +
 rtl/mac_feeder.sv | 117 +++++++++++
 tb/tb_mac_feeder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_feeder_pkg.sv
// Shared types and constants for the mac_feeder operand sequencer.
package mac_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/mac_feeder.sv
// Operand sequencer for the 4-lane MAC wrapper: issues one operand chunk per
// MAC pass, loops each returned psum back on c and presents the final psum.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int mac_lat = 1,
  parameter int len_bw  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [len_bw-1:0]         len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_LANES*bw-1:0]   in_a,
  input  logic [NUM_LANES*bw-1:0]   in_b,
  output logic [bw-1:0]             a0,
  output logic [bw-1:0]             b0,
  output logic [bw-1:0]             a1,
  output logic [bw-1:0]             b1,
  output logic [bw-1:0]             a2,
  output logic [bw-1:0]             b2,
  output logic [bw-1:0]             a3,
  output logic [bw-1:0]             b3,
  output logic [psum_bw-1:0]        c,
  input  logic [psum_bw-1:0]        mac_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [psum_bw-1:0]        res_data,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(mac_lat);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [len_bw-1:0]         count_q;
  logic [len_bw-1:0]         count_inc;
  logic [len_bw-1:0]         len_q;
  logic [psum_bw-1:0]        acc_q;
  logic [NUM_LANES*bw-1:0]   a_q, b_q;
  logic [psum_bw-1:0]        c_q;
  logic [psum_bw-1:0]        res_q;
  logic                      accept, capture, last;

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ISSUE);
    res_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    accept    = (state_q == ISSUE) && in_valid;
    capture   = (state_q == WAIT) && (cnt_q == '0);
    last      = capture && (count_inc == len_q);
    case (state_q)
      IDLE:    if (start) state_d = (len != '0) ? ISSUE : DONE;
      ISSUE:   if (in_valid) state_d = WAIT;
      WAIT:    if (capture) state_d = last ? DONE : ISSUE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        len_q   <= len;
        acc_q   <= '0;
        count_q <= '0;
        if (len == '0) res_q <= '0;
      end
      // Issue stage: operands and running sum go out together.
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        c_q   <= acc_q;
        cnt_q <= LAT;
      end
      // Wait stage: count down the MAC latency, then take its result.
      if (state_q == WAIT) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          acc_q   <= mac_out;
          count_q <= count_inc;
          if (last) res_q <= mac_out;
        end
      end
    end
  end

  assign a0       = a_q[0*bw +: bw];
  assign a1       = a_q[1*bw +: bw];
  assign a2       = a_q[2*bw +: bw];
  assign a3       = a_q[3*bw +: bw];
  assign b0       = b_q[0*bw +: bw];
  assign b1       = b_q[1*bw +: bw];
  assign b2       = b_q[2*bw +: bw];
  assign b3       = b_q[3*bw +: bw];
  assign c        = c_q;
  assign res_data = res_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Closed-loop bench: three mac_feeder instances (16b/lat1, 8b/lat1, 8b/lat3)
// each driving a small behavioural MAC wrapper.
module tb_mac_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_a, in_b;
  logic        res_ready;
  int          sel;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  logic [3:0]  la [3][4];
  logic [3:0]  lb [3][4];
  logic [15:0] c0;
  logic [7:0]  c1, c2;
  logic [15:0] mo0;
  logic [7:0]  mo1, mo2;
  logic [2:0]  rdy, rv, bsy;
  logic [15:0] rd0;
  logic [7:0]  rd1, rd2;

  mac_feeder #(.bw(4), .psum_bw(16), .mac_lat(1), .len_bw(8)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .len(len),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_a(in_a), .in_b(in_b),
    .a0(la[0][0]), .b0(lb[0][0]), .a1(la[0][1]), .b1(lb[0][1]),
    .a2(la[0][2]), .b2(lb[0][2]), .a3(la[0][3]), .b3(lb[0][3]),
    .c(c0), .mac_out(mo0), .res_valid(rv[0]), .res_ready(res_ready),
    .res_data(rd0), .busy(bsy[0]));

  mac_feeder #(.bw(4), .psum_bw(8), .mac_lat(1), .len_bw(8)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .len(len),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_a(in_a), .in_b(in_b),
    .a0(la[1][0]), .b0(lb[1][0]), .a1(la[1][1]), .b1(lb[1][1]),
    .a2(la[1][2]), .b2(lb[1][2]), .a3(la[1][3]), .b3(lb[1][3]),
    .c(c1), .mac_out(mo1), .res_valid(rv[1]), .res_ready(res_ready),
    .res_data(rd1), .busy(bsy[1]));

  mac_feeder #(.bw(4), .psum_bw(8), .mac_lat(3), .len_bw(8)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .len(len),
    .in_valid(in_valid), .in_ready(rdy[2]), .in_a(in_a), .in_b(in_b),
    .a0(la[2][0]), .b0(lb[2][0]), .a1(la[2][1]), .b1(lb[2][1]),
    .a2(la[2][2]), .b2(lb[2][2]), .a3(la[2][3]), .b3(lb[2][3]),
    .c(c2), .mac_out(mo2), .res_valid(rv[2]), .res_ready(res_ready),
    .res_data(rd2), .busy(bsy[2]));

  // Behavioural MAC wrapper: input register plus (lat-1) extra stages.
  function automatic logic [15:0] dot4(input logic [3:0] x0, x1, x2, x3,
                                       input logic [3:0] y0, y1, y2, y3,
                                       input logic [15:0] acc);
    return {12'b0, x0} * {12'b0, y0} + {12'b0, x1} * {12'b0, y1}
         + {12'b0, x2} * {12'b0, y2} + {12'b0, x3} * {12'b0, y3} + acc;
  endfunction

  logic [15:0] s0, s1, s2;
  logic [7:0]  d2a, d2b;
  always_comb begin
    s0 = dot4(la[0][0], la[0][1], la[0][2], la[0][3], lb[0][0], lb[0][1], lb[0][2], lb[0][3], c0);
    s1 = dot4(la[1][0], la[1][1], la[1][2], la[1][3], lb[1][0], lb[1][1], lb[1][2], lb[1][3], {8'b0, c1});
    s2 = dot4(la[2][0], la[2][1], la[2][2], la[2][3], lb[2][0], lb[2][1], lb[2][2], lb[2][3], {8'b0, c2});
  end
  initial begin mo0 = '0; mo1 = '0; mo2 = '0; d2a = '0; d2b = '0; end
  always @(posedge clk) begin
    mo0 <= s0;
    mo1 <= s1[7:0];
    d2a <= s2[7:0];
    d2b <= d2a;
    mo2 <= d2b;
  end

  logic        sel_rdy, sel_rv, sel_busy;
  logic [15:0] sel_rd, sel_c;
  always_comb begin
    sel_rdy  = rdy[0];
    sel_rv   = rv[0];
    sel_busy = bsy[0];
    sel_rd   = rd0;
    sel_c    = c0;
    if (sel == 1) begin
      sel_rdy = rdy[1]; sel_rv = rv[1]; sel_busy = bsy[1]; sel_rd = {8'b0, rd1}; sel_c = {8'b0, c1};
    end else if (sel == 2) begin
      sel_rdy = rdy[2]; sel_rv = rv[2]; sel_busy = bsy[2]; sel_rd = {8'b0, rd2}; sel_c = {8'b0, c2};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int l);
    len = 8'(l);
    start_v[sel] = 1'b1;
    tick();
    start_v = '0;
    len = 8'hAA;
  endtask

  // Waits (bounded) for in_ready, then presents the chunk across one edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int k;
    k = 0;
    while (!sel_rdy && k < 20) begin
      tick();
      k++;
    end
    if (!sel_rdy) begin
      n_errors++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1");
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = 16'hFFFF;
    in_b = 16'hFFFF;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_v = '0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0; sel = 0;
    repeat (2) tick();
    chk("rst_busy", bsy, 0);
    chk("rst_ops", {la[0][3], la[0][2], la[0][1], la[0][0], lb[0][3], lb[0][2], lb[0][1], lb[0][0]}, 0);
    chk("rst_c", c0, 0);
    chk("rst_ready_valid", {rdy, rv}, 0);
    chk("rst_res_data", rd0, 0);
    reset = 1'b0;
    tick();

    // Single chunk, combinational MAC core.
    start_op(1);
    issue(16'h4321, 16'h1111);
    chk("t1_c", c0, 0);
    chk("t1_ops_a", {la[0][3], la[0][2], la[0][1], la[0][0]}, 16'h4321);
    chk("t1_rv_T0", rv[0], 0);
    tick();
    chk("t1_rv_T1", rv[0], 0);
    tick();
    chk("t1_rv_T2", rv[0], 1);
    chk("t1_res", rd0, 10);
    handshake();
    chk("t1_idle", bsy[0], 0);

    // Three chunks with input gaps.
    start_op(3);
    for (int k = 0; k < 3; k++) begin
      issue(16'h2222, 16'h2222);
      chk("t2_c", c0, 16 * k);
      chk("t2_wait_rdy0", rdy[0], 0);
      tick();
      chk("t2_wait_rdy1", rdy[0], 0);
      tick();
      if (k < 2) begin
        chk("t2_issue_rdy", rdy[0], 1);
        repeat (2) begin
          tick();
          chk("t2_gap_rdy", rdy[0], 1);
        end
      end
    end
    chk("t2_rv", rv[0], 1);
    chk("t2_res", rd0, 48);

    // Result held under back-pressure; start ignored in DONE.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start_v[0] = 1'b1;
      len = 8'd1;
      tick();
      start_v = '0;
      chk("t4_rv_hold", rv[0], 1);
      chk("t4_rd_hold", rd0, 48);
    end
    handshake();
    chk("t4_idle_busy", bsy[0], 0);
    chk("t4_idle_rv", rv[0], 0);
    tick();
    chk("t4_no_restart", bsy[0], 0);

    // Zero-length operation.
    start_op(0);
    chk("t3_rdy", rdy[0], 0);
    chk("t3_rv", rv[0], 1);
    chk("t3_res", rd0, 0);
    handshake();
    chk("t3_idle", {bsy[0], rv[0]}, 0);

    // Async reset mid-operation, then a clean run.
    start_op(3);
    issue(16'h2222, 16'h2222);
    tick();
    tick();
    issue(16'h2222, 16'h2222);
    chk("t5_c_pre", c0, 16);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", bsy[0], 0);
    chk("t5_c", c0, 0);
    chk("t5_ops", {la[0][3], la[0][2], la[0][1], la[0][0], lb[0][3], lb[0][2], lb[0][1], lb[0][0]}, 0);
    chk("t5_rdy_rv", {rdy[0], rv[0]}, 0);
    chk("t5_res", rd0, 0);
    #2 reset = 1'b0;
    tick();
    start_op(1);
    issue(16'h4321, 16'h1111);
    chk("t5_c_after", c0, 0);
    tick();
    tick();
    chk("t5_rv_after", rv[0], 1);
    chk("t5_res_after", rd0, 10);
    handshake();

    // 8-bit psum wrap, combinational core.
    sel = 1;
    start_op(2);
    issue(16'h7777, 16'h7777);
    chk("t6a_c0", sel_c, 0);
    tick();
    tick();
    issue(16'h7777, 16'h7777);
    chk("t6a_c1", sel_c, 196);
    tick();
    tick();
    chk("t6a_rv", sel_rv, 1);
    chk("t6a_res", sel_rd, 136);
    handshake();
    chk("t6a_idle", sel_busy, 0);

    // 8-bit psum wrap, three-edge MAC latency.
    sel = 2;
    start_op(2);
    issue(16'h7777, 16'h7777);
    chk("t6b_c0", sel_c, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t6b_wait_rdy", sel_rdy, 0);
    end
    tick();
    chk("t6b_capture_rdy", sel_rdy, 1);
    issue(16'h7777, 16'h7777);
    chk("t6b_c1", sel_c, 196);
    repeat (3) tick();
    chk("t6b_rv_T3", sel_rv, 0);
    tick();
    chk("t6b_rv_T4", sel_rv, 1);
    chk("t6b_res", sel_rd, 136);
    handshake();
    chk("t6b_idle", sel_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
